// File: rtl/uart_pkt_pkg.sv
// Shared types and helpers for the UART packet framer.
package uart_pkt_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam logic [BYTE_W-1:0] SOF_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_SOF,
    ST_LEN,
    ST_DATA,
    ST_CHK
  } state_e;

  typedef enum logic {
    PH_ISSUE,
    PH_WAIT
  } phase_e;

  // Two's-complement of the running LEN+payload sum, so the frame sums to zero.
  function automatic logic [BYTE_W-1:0] chk_final(input logic [BYTE_W-1:0] sum);
    return (~sum) + 8'd1;
  endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload register file: synchronous write, combinational read.
module uart_pkt_buf #(
  parameter  int unsigned MAX_LEN = 16,
  localparam int unsigned AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_pkt_tx.sv
// Frames a buffered payload as SOF, LEN, payload, CHK over the UART TX byte handshake.
module uart_pkt_tx
  import uart_pkt_pkg::*;
#(
  parameter int unsigned MAX_LEN  = 16,
  parameter logic [7:0]  SOF_BYTE = SOF_BYTE_DEFAULT,
  parameter int unsigned GUARD    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       s_ready,
  output logic       tx_en,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       pkt_busy,
  output logic       ovf_o
);

  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned GW = $clog2(GUARD + 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [GW-1:0] GUARD_G   = GW'(GUARD);

  state_e        state_q;
  phase_e        phase_q;
  logic [7:0]    count_q;
  logic [AW-1:0] idx_q;
  logic [7:0]    sum_q;
  logic [GW-1:0] guard_q;
  logic          tx_en_q;
  logic [7:0]    tx_data_q;
  logic          s_ready_q;
  logic          pkt_busy_q;
  logic          ovf_q;

  state_e        adv_state_d;
  logic [AW-1:0] adv_idx_d;
  state_e        sel_state_d;
  logic [AW-1:0] sel_idx_d;
  logic [7:0]    sel_byte_d;
  logic [7:0]    rdata;
  logic          accept_d;
  logic          buf_we_d;

  assign accept_d = s_valid && (count_q < MAX_LEN_B);
  assign buf_we_d = (state_q == ST_FILL) && accept_d;

  uart_pkt_buf #(
    .MAX_LEN (MAX_LEN)
  ) u_buf (
    .clk     (clk),
    .we_i    (buf_we_d),
    .waddr_i (count_q[AW-1:0]),
    .wdata_i (s_data),
    .raddr_i (sel_idx_d),
    .rdata_o (rdata)
  );

  // Successor of the current state once its byte has been handed over.
  always_comb begin
    adv_state_d = ST_FILL;
    adv_idx_d   = '0;
    unique case (state_q)
      ST_FILL: adv_state_d = ST_SOF;
      ST_SOF:  adv_state_d = ST_LEN;
      ST_LEN:  adv_state_d = ST_DATA;
      ST_DATA: begin
        if (8'(idx_q) == count_q - 8'd1) begin
          adv_state_d = ST_CHK;
        end else begin
          adv_state_d = ST_DATA;
          adv_idx_d   = idx_q + AW'(1);
        end
      end
      ST_CHK:  adv_state_d = ST_FILL;
      default: adv_state_d = ST_FILL;
    endcase
  end

  // Byte to launch: the successor's when leaving FILL/WAIT, else the stalled ISSUE's own.
  always_comb begin
    sel_state_d = state_q;
    sel_idx_d   = idx_q;
    if ((state_q == ST_FILL) || (phase_q == PH_WAIT)) begin
      sel_state_d = adv_state_d;
      sel_idx_d   = adv_idx_d;
    end
    sel_byte_d = '0;
    unique case (sel_state_d)
      ST_SOF:  sel_byte_d = SOF_BYTE;
      ST_LEN:  sel_byte_d = count_q;
      ST_DATA: sel_byte_d = rdata;
      ST_CHK:  sel_byte_d = chk_final(count_q + sum_q);
      default: sel_byte_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_FILL;
      phase_q    <= PH_ISSUE;
      count_q    <= '0;
      idx_q      <= '0;
      sum_q      <= '0;
      guard_q    <= '0;
      tx_en_q    <= 1'b0;
      tx_data_q  <= '0;
      s_ready_q  <= 1'b1;
      pkt_busy_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      tx_en_q <= 1'b0;
      ovf_q   <= 1'b0;
      if (state_q == ST_FILL) begin
        if (s_valid) begin
          if (accept_d) begin
            count_q <= count_q + 8'd1;
            sum_q   <= sum_q + s_data;
          end else begin
            ovf_q <= 1'b1;
          end
          // A dropped last beat still closes the packet.
          if (s_last) begin
            state_q    <= ST_SOF;
            phase_q    <= PH_ISSUE;
            idx_q      <= '0;
            s_ready_q  <= 1'b0;
            pkt_busy_q <= 1'b1;
            if (!tx_busy) begin
              tx_en_q   <= 1'b1;
              tx_data_q <= sel_byte_d;
            end
          end
        end
      end else if (phase_q == PH_ISSUE) begin
        if (tx_en_q) begin
          phase_q <= PH_WAIT;
          guard_q <= '0;
        end else if (!tx_busy) begin
          tx_en_q   <= 1'b1;
          tx_data_q <= sel_byte_d;
        end
      end else if (guard_q != GUARD_G) begin
        guard_q <= guard_q + GW'(1);
      end else if (!tx_busy) begin
        state_q <= adv_state_d;
        idx_q   <= adv_idx_d;
        phase_q <= PH_ISSUE;
        if (adv_state_d == ST_FILL) begin
          count_q    <= '0;
          sum_q      <= '0;
          s_ready_q  <= 1'b1;
          pkt_busy_q <= 1'b0;
        end else begin
          tx_en_q   <= 1'b1;
          tx_data_q <= sel_byte_d;
        end
      end
    end
  end

  assign s_ready  = s_ready_q;
  assign tx_en    = tx_en_q;
  assign tx_data  = tx_data_q;
  assign pkt_busy = pkt_busy_q;
  assign ovf_o    = ovf_q;

endmodule
